// File: rtl/fir_filter.sv
// ---------------------------------------------------------------------------
// fir_filter
//   Direct-form FIR filter with unsigned compile-time coefficients and a
//   registered output. Each enabled clock edge takes in one sample, registers
//   one filtered result and shifts the delay line. The result appears one
//   clock after its sample.
//
// Parameters
//   NUM_TABS        number of taps (>= 1)
//   TAB_WIDTH       bits per unsigned coefficient
//   DATA_IN_WIDTH   bits per unsigned input sample
//   DATA_OUT_WIDTH  output width
//   COEFFS          packed coefficients, h[k] = COEFFS[k*TAB_WIDTH +: TAB_WIDTH]
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset; clears delay line and output
//   clk_en    in   sample enable; 0 freezes delay line and output
//   data_in   in   unsigned input sample x[n]
//   data_out  out  registered unsigned filter output y
//
// Build option
//   FIR_SATURATE_EN  when defined, an accumulator value that does not fit in
//                    DATA_OUT_WIDTH clamps to all ones. When undefined, the
//                    upper bits are dropped (modulo 2^DATA_OUT_WIDTH).
// ---------------------------------------------------------------------------
module fir_filter #(
  parameter int NUM_TABS       = 3,
  parameter int TAB_WIDTH      = 3,
  parameter int DATA_IN_WIDTH  = 8,
  parameter int DATA_OUT_WIDTH = TAB_WIDTH + DATA_IN_WIDTH + 8,
  parameter logic [NUM_TABS*TAB_WIDTH-1:0] COEFFS = {3'd3, 3'd2, 3'd1}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_en,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  output logic [DATA_OUT_WIDTH-1:0] data_out
);

  // Each product needs TAB_WIDTH+DATA_IN_WIDTH bits. Summing NUM_TABS of
  // them needs clog2(NUM_TABS) more bits, so the sum cannot overflow.
  localparam int PROD_W = TAB_WIDTH + DATA_IN_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NUM_TABS);
  localparam int EXT_W  = (ACC_W > DATA_OUT_WIDTH) ? ACC_W : DATA_OUT_WIDTH;
  // Keep at least one delay-line entry so the array stays legal for NUM_TABS=1.
  localparam int DL_N   = (NUM_TABS > 1) ? NUM_TABS - 1 : 1;

  logic [DATA_IN_WIDTH-1:0] x_d [DL_N];
  logic [ACC_W-1:0]         acc_p0;

  // Fit the full-precision accumulator to the output width. Narrower values
  // are zero-extended. Wider values either wrap or clamp to all ones.
  function automatic logic [DATA_OUT_WIDTH-1:0] fit_out(input logic [ACC_W-1:0] a);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(a);
`ifdef FIR_SATURATE_EN
    if (ext > EXT_W'({DATA_OUT_WIDTH{1'b1}})) begin
      return {DATA_OUT_WIDTH{1'b1}};
    end
`endif
    return ext[DATA_OUT_WIDTH-1:0];
  endfunction

  // ---- stage p0: multiply-accumulate over the current sample and history ----
  always_comb begin
    acc_p0 = ACC_W'(COEFFS[TAB_WIDTH-1:0]) * ACC_W'(data_in);
    for (int k = 1; k < NUM_TABS; k++) begin
      acc_p0 = acc_p0
             + ACC_W'(COEFFS[k*TAB_WIDTH +: TAB_WIDTH]) * ACC_W'(x_d[k-1]);
    end
  end

  // ---- stage p1: output register, updated only on enabled edges ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (clk_en) begin
      data_out <= fit_out(acc_p0);
    end
  end

  // Delay line. It shifts on the same enabled edge that registers the output,
  // so the output above always uses the history from before this shift.
  generate
    if (NUM_TABS > 1) begin : g_dly
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DL_N; k++) begin
            x_d[k] <= '0;
          end
        end else if (clk_en) begin
          x_d[0] <= data_in;
          for (int k = 1; k < DL_N; k++) begin
            x_d[k] <= x_d[k-1];
          end
        end
      end
    end else begin : g_no_dly
      // With a single tap there is no history. The single unused entry stays
      // at zero and contributes nothing to the sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_d[0] <= '0;
        end else begin
          x_d[0] <= '0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fir_filter.sv
// ---------------------------------------------------------------------------
// tb_fir_filter
//   Directed bench for fir_filter with default coefficients h = {1,2,3}.
//   A second instance with a 4-bit output covers the wrap/saturate boundary.
// ---------------------------------------------------------------------------
module tb_fir_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic [7:0]  data_in;
  logic [18:0] data_out;
  logic [3:0]  data_out_narrow;

  int total = 0;
  int bad   = 0;

  fir_filter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .data_in  (data_in),
    .data_out (data_out)
  );

  fir_filter #(.DATA_OUT_WIDTH(4)) dut_narrow (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .data_in  (data_in),
    .data_out (data_out_narrow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge. Inputs are applied and outputs sampled 1 time unit after
  // the rising edge.
  task automatic step(input logic en, input logic [7:0] din);
    clk_en  = en;
    data_in = din;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] narrow_exp;

  initial begin
    rst_n   = 1'b1;
    clk_en  = 1'b0;
    data_in = 'x;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async", data_out, 19'd0);

    // Reset held across enabled edges with X input.
    clk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_hold_1", data_out, 19'd0);
    @(posedge clk); #1;
    chk("reset_hold_2", data_out, 19'd0);

    // Release reset. A disabled edge must leave the output at 0.
    rst_n = 1'b1;
    clk_en = 1'b0;
    @(posedge clk); #1;
    chk("post_release_idle", data_out, 19'd0);

    // Step sequence 1,1,0,0,0 -> 1,3,5,3,0
    step(1'b1, 8'd1); chk("seq_0", data_out, 19'd1);
    step(1'b1, 8'd1); chk("seq_1", data_out, 19'd3);
    step(1'b1, 8'd0); chk("seq_2", data_out, 19'd5);
    step(1'b1, 8'd0); chk("seq_3", data_out, 19'd3);
    step(1'b1, 8'd0); chk("seq_4", data_out, 19'd0);

    // Impulse response reads back the coefficients.
    step(1'b1, 8'd1); chk("imp_0", data_out, 19'd1);
    step(1'b1, 8'd0); chk("imp_1", data_out, 19'd2);
    step(1'b1, 8'd0); chk("imp_2", data_out, 19'd3);
    step(1'b1, 8'd0); chk("imp_3", data_out, 19'd0);

    // Full-scale steady input: 255, 765, then 1530.
    step(1'b1, 8'd255); chk("max_0", data_out, 19'd255);
    step(1'b1, 8'd255); chk("max_1", data_out, 19'd765);
    step(1'b1, 8'd255); chk("max_2", data_out, 19'd1530);
    step(1'b1, 8'd255); chk("max_3", data_out, 19'd1530);
`ifdef FIR_SATURATE_EN
    narrow_exp = 4'd15;
`else
    narrow_exp = 4'd10;
`endif
    chk("narrow_out", 19'(data_out_narrow), 19'(narrow_exp));

    // Flush the history: 0 + 2*255 + 3*255 = 1275, then 3*255 = 765.
    step(1'b1, 8'd0); chk("flush_0", data_out, 19'd1275);
    step(1'b1, 8'd0); chk("flush_1", data_out, 19'd765);

    // Start an impulse, freeze for 3 cycles with data changing, then resume.
    step(1'b1, 8'd1);   chk("frz_pre", data_out, 19'd1);
    step(1'b0, 8'd7);   chk("frz_0",   data_out, 19'd1);
    step(1'b0, 8'd9);   chk("frz_1",   data_out, 19'd1);
    step(1'b0, 8'd200); chk("frz_2",   data_out, 19'd1);
    step(1'b1, 8'd0);   chk("frz_res_0", data_out, 19'd2);
    step(1'b1, 8'd0);   chk("frz_res_1", data_out, 19'd3);
    step(1'b1, 8'd0);   chk("frz_res_2", data_out, 19'd0);

    // Reset mid-stream. The history of 5 must be lost.
    step(1'b1, 8'd5); chk("mid_pre", data_out, 19'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_async", data_out, 19'd0);
    #1 rst_n = 1'b1;
    step(1'b1, 8'd1); chk("mid_post_0", data_out, 19'd1);
    step(1'b1, 8'd0); chk("mid_post_1", data_out, 19'd2);
    step(1'b1, 8'd0); chk("mid_post_2", data_out, 19'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
